// File: rtl/risc_v_mike_pkg.sv
// Shared definitions for the memory region controller: region map, wait states, FSM states.
package risc_v_mike_pkg;
  localparam int MAX_REGIONS = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} mem_ctrl_state_t;

  // Unused slots have base above last so they can never hit.
  localparam logic [31:0] REGION_BASE [MAX_REGIONS] = '{
    32'h0040_0000, 32'h1001_0000, 32'h7FFF_E000, 32'hFFFF_0000,
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  localparam logic [31:0] REGION_LAST [MAX_REGIONS] = '{
    32'h0040_0FFF, 32'h1001_0FFF, 32'h7FFF_EFFF, 32'hFFFF_FFFF,
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [3:0]  REGION_WAIT [MAX_REGIONS] = '{
    4'd0, 4'd1, 4'd1, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0};
endpackage

// File: rtl/risc_v_mem_region_ctrl_if.sv
// Core-side memory bus and region-select bundle between core and region controller.
interface risc_v_mem_region_ctrl_if #(
  parameter int ADDR_W    = 32,
  parameter int N_REGIONS = 4
);
  logic                 bus_req_valid;
  logic                 bus_req_write;
  logic [ADDR_W-1:0]    bus_req_addr;
  logic                 bus_req_ready;
  logic [N_REGIONS-1:0] region_sel;
  logic [ADDR_W-1:0]    region_addr;
  logic                 region_write;
  logic                 bus_rsp_valid;
  logic                 bus_rsp_error;
  logic [2:0]           bus_rsp_region;

  modport master (
    output bus_req_valid, bus_req_write, bus_req_addr,
    input  bus_req_ready, region_sel, region_addr, region_write,
           bus_rsp_valid, bus_rsp_error, bus_rsp_region
  );
  modport slave (
    input  bus_req_valid, bus_req_write, bus_req_addr,
    output bus_req_ready, region_sel, region_addr, region_write,
           bus_rsp_valid, bus_rsp_error, bus_rsp_region
  );
endinterface

// File: rtl/risc_v_mem_region_decode.sv
// Combinational address decoder: address -> hit, lowest matching region index, offset.
module risc_v_mem_region_decode
  import risc_v_mike_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int N_REGIONS = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [2:0]        idx_o,
  output logic [ADDR_W-1:0] offset_o
);
  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit_o    = 1'b0;
    idx_o    = 3'd0;
    offset_o = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (addr_i >= ADDR_W'(REGION_BASE[i]) && addr_i <= ADDR_W'(REGION_LAST[i])) begin
        hit_o    = 1'b1;
        idx_o    = 3'(i);
        offset_o = addr_i - ADDR_W'(REGION_BASE[i]);
      end
    end
  end
endmodule

// File: rtl/risc_v_mem_region_ctrl.sv
// Registered region controller: accept, decode, hold region select for wait states, respond.
// Optional MEM_CTRL_MISALIGN_CHK_EN rejects requests with addr[1:0] != 0.
module risc_v_mem_region_ctrl
  import risc_v_mike_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int N_REGIONS = 4,
  parameter int WAIT_W    = 4
) (
  input  logic clk,
  input  logic rst,
  risc_v_mem_region_ctrl_if.slave bus
);
  mem_ctrl_state_t      state_q, state_d;
  logic [WAIT_W-1:0]    cnt_q, cnt_d;
  logic [N_REGIONS-1:0] sel_q, sel_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic                 wr_q, wr_d;
  logic [2:0]           idx_q, idx_d;
  logic                 ready_q, ready_d;
  logic                 rv_q, rv_d, re_q, re_d;
  logic [2:0]           rr_q, rr_d;

  logic                 dec_hit, misalign, accept;
  logic [2:0]           dec_idx;
  logic [ADDR_W-1:0]    dec_off;

  risc_v_mem_region_decode #(.ADDR_W(ADDR_W), .N_REGIONS(N_REGIONS)) u_dec (
    .addr_i  (bus.bus_req_addr),
    .hit_o   (dec_hit),
    .idx_o   (dec_idx),
    .offset_o(dec_off)
  );

`ifdef MEM_CTRL_MISALIGN_CHK_EN
  assign misalign = (bus.bus_req_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign accept = bus.bus_req_valid && ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    rv_d    = 1'b0;
    re_d    = 1'b0;
    rr_d    = 3'd0;
    unique case (state_q)
      IDLE: if (accept) begin
        if (dec_hit && !misalign) begin
          state_d = ACCESS;
          sel_d   = N_REGIONS'(1) << dec_idx;
          addr_d  = dec_off;
          wr_d    = bus.bus_req_write;
          idx_d   = dec_idx;
          cnt_d   = WAIT_W'(REGION_WAIT[dec_idx]);
        end else begin
          state_d = RESP;
          rv_d    = 1'b1;
          re_d    = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          sel_d   = '0;
          addr_d  = '0;
          wr_d    = 1'b0;
          rv_d    = 1'b1;
          rr_d    = idx_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Ready is registered so it stays low throughout reset and comes up on the first edge after.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      idx_q   <= 3'd0;
      ready_q <= 1'b0;
      rv_q    <= 1'b0;
      re_q    <= 1'b0;
      rr_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      rv_q    <= rv_d;
      re_q    <= re_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.bus_req_ready  = ready_q;
  assign bus.region_sel     = sel_q;
  assign bus.region_addr    = addr_q;
  assign bus.region_write   = wr_q;
  assign bus.bus_rsp_valid  = rv_q;
  assign bus.bus_rsp_error  = re_q;
  assign bus.bus_rsp_region = rr_q;
endmodule

// File: tb/tb_risc_v_mem_region_ctrl.sv
// Directed bench for risc_v_mem_region_ctrl with hand-computed expectations.
module tb_risc_v_mem_region_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  risc_v_mem_region_ctrl_if #(.ADDR_W(32), .N_REGIONS(4)) bus ();

  risc_v_mem_region_ctrl #(.ADDR_W(32), .N_REGIONS(4), .WAIT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.bus_req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready_timeout"}, 32'(bus.bus_req_ready), 32'd1);
  endtask

  // Full single transaction: issue at a negedge, accept on the next posedge (edge T).
  task automatic run_req(input string tag, input logic [31:0] a, input logic w, input logic hit,
                         input logic [3:0] sel, input logic [31:0] off, input int wt,
                         input logic [2:0] rgn);
    wait_ready(tag);
    bus.bus_req_valid = 1'b1;
    bus.bus_req_write = w;
    bus.bus_req_addr  = a;
    @(posedge clk);
    @(negedge clk);
    bus.bus_req_valid = 1'b0;
    bus.bus_req_addr  = 32'h1001_0000;
    if (hit) begin
      for (int k = 0; k <= wt; k++) begin
        chk({tag, " sel"},   32'(bus.region_sel), 32'(sel));
        chk({tag, " off"},   bus.region_addr, off);
        chk({tag, " wr"},    32'(bus.region_write), 32'(w));
        chk({tag, " rsp0"},  32'(bus.bus_rsp_valid), 32'd0);
        chk({tag, " rdy0"},  32'(bus.bus_req_ready), 32'd0);
        @(negedge clk);
      end
    end
    chk({tag, " rsp"},     32'(bus.bus_rsp_valid), 32'd1);
    chk({tag, " err"},     32'(bus.bus_rsp_error), 32'(!hit));
    chk({tag, " rgn"},     32'(bus.bus_rsp_region), 32'(rgn));
    chk({tag, " sel_rsp"}, 32'(bus.region_sel), 32'd0);
    chk({tag, " wr_rsp"},  32'(bus.region_write), 32'd0);
    chk({tag, " rdy_rsp"}, 32'(bus.bus_req_ready), 32'd0);
    @(negedge clk);
    chk({tag, " rsp_end"}, 32'(bus.bus_rsp_valid), 32'd0);
    chk({tag, " rdy_end"}, 32'(bus.bus_req_ready), 32'd1);
  endtask

  initial begin
    bus.bus_req_valid = 1'b0;
    bus.bus_req_write = 1'b0;
    bus.bus_req_addr  = '0;
    repeat (2) @(negedge clk);
    chk("reset ready",  32'(bus.bus_req_ready), 32'd0);
    chk("reset sel",    32'(bus.region_sel), 32'd0);
    chk("reset rsp",    32'(bus.bus_rsp_valid), 32'd0);
    chk("reset addr",   bus.region_addr, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post-reset ready", 32'(bus.bus_req_ready), 32'd1);

    run_req("text rd",   32'h0040_0004, 1'b0, 1'b1, 4'b0001, 32'h4,   0, 3'd0);
    run_req("mmio wr",   32'hFFFF_0010, 1'b1, 1'b1, 4'b1000, 32'h10,  3, 3'd3);
    run_req("miss",      32'h10F1_0000, 1'b0, 1'b0, 4'b0000, 32'h0,   0, 3'd0);
    run_req("text last", 32'h0040_0FFF, 1'b0, 1'b1, 4'b0001, 32'hFFF, 0, 3'd0);
    run_req("text+1",    32'h0040_1000, 1'b1, 1'b0, 4'b0000, 32'h0,   0, 3'd0);
    run_req("mmio top",  32'hFFFF_FFFF, 1'b0, 1'b1, 4'b1000, 32'hFFFF,3, 3'd3);

    // Back-to-back with valid held: new address during service must be ignored.
    wait_ready("b2b");
    bus.bus_req_valid = 1'b1;
    bus.bus_req_write = 1'b0;
    bus.bus_req_addr  = 32'h1001_0000;
    @(posedge clk);
    @(negedge clk);
    bus.bus_req_addr  = 32'h7FFF_EFFC;
    chk("b2b1 sel", 32'(bus.region_sel), 32'h2);
    chk("b2b1 off", bus.region_addr, 32'h0);
    @(negedge clk);
    chk("b2b1 sel2", 32'(bus.region_sel), 32'h2);
    chk("b2b1 off2", bus.region_addr, 32'h0);
    @(negedge clk);
    chk("b2b1 rsp", 32'(bus.bus_rsp_valid), 32'd1);
    chk("b2b1 rgn", 32'(bus.bus_rsp_region), 32'd1);
    chk("b2b1 rdy", 32'(bus.bus_req_ready), 32'd0);
    @(negedge clk);
    chk("b2b ready back", 32'(bus.bus_req_ready), 32'd1);
    chk("b2b idle sel", 32'(bus.region_sel), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.bus_req_valid = 1'b0;
    chk("b2b2 sel", 32'(bus.region_sel), 32'h4);
    chk("b2b2 off", bus.region_addr, 32'hFFC);
    @(negedge clk);
    chk("b2b2 sel2", 32'(bus.region_sel), 32'h4);
    @(negedge clk);
    chk("b2b2 rsp", 32'(bus.bus_rsp_valid), 32'd1);
    chk("b2b2 rgn", 32'(bus.bus_rsp_region), 32'd2);
    @(negedge clk);

    // Reset in the middle of an MMIO access drops it without a response.
    wait_ready("rst mid");
    bus.bus_req_valid = 1'b1;
    bus.bus_req_addr  = 32'hFFFF_0000;
    @(posedge clk);
    @(negedge clk);
    bus.bus_req_valid = 1'b0;
    chk("rst mid sel", 32'(bus.region_sel), 32'h8);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst async sel", 32'(bus.region_sel), 32'd0);
    chk("rst async rdy", 32'(bus.bus_req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst no rsp", 32'(bus.bus_rsp_valid), 32'd0);
    end
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("after rst no rsp", 32'(bus.bus_rsp_valid), 32'd0);
    end
    run_req("after rst", 32'h0040_0008, 1'b0, 1'b1, 4'b0001, 32'h8, 0, 3'd0);

`ifdef MEM_CTRL_MISALIGN_CHK_EN
    run_req("misalign", 32'h1001_0002, 1'b0, 1'b0, 4'b0000, 32'h0, 0, 3'd0);
`else
    run_req("misalign", 32'h1001_0002, 1'b0, 1'b1, 4'b0010, 32'h2, 1, 3'd1);
`endif
    run_req("stack wr", 32'h7FFF_E010, 1'b1, 1'b1, 4'b0100, 32'h10, 1, 3'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/risc_v_mem_region_ctrl.md
# risc_v_mem_region_ctrl

Parametrised, registered successor to the fixed four-region memory bus decoder. Accepts one core memory request at a time via a valid/ready handshake, decodes it against N configurable address regions, drives a registered one-hot region select with region-relative offset, holds it for a per-region number of wait states, then returns a one-cycle response (with error for unmapped addresses). Sits between the core's memory bus and the text/data/stack/MMIO back-ends.

## Interface
Parameters:
- ADDR_W, 32, request address and offset width
- N_REGIONS, 4, number of decoded regions (1..8)
- WAIT_W, 4, width of the per-region wait-state counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- bus_req_valid  in  1  request present
- bus_req_write  in  1  1 = write, 0 = read
- bus_req_addr  in  ADDR_W  byte address
- bus_req_ready  out  1  controller can accept a request
- region_sel  out  N_REGIONS  one-hot selected region; zero when idle
- region_addr  out  ADDR_W  bus_req_addr minus region base
- region_write  out  1  write strobe qualifier, valid with region_sel
- bus_rsp_valid  out  1  one-cycle response pulse
- bus_rsp_error  out  1  unmapped or rejected access, valid with bus_rsp_valid
- bus_rsp_region  out  3  index of serviced region; 0 on error

## Operation
- Region i hit: REGION_BASE[i] <= addr <= REGION_LAST[i] (inclusive bounds, no overflow at 0xFFFFFFFF).
- Overlapping hits: lowest index wins; no hit: error.
- FSM states IDLE, ACCESS, RESP.
- IDLE: bus_req_ready=1. On valid&&ready: hit -> ACCESS, register region_sel/region_addr/region_write, load wait counter with REGION_WAIT[i]; miss -> RESP with error.
- ACCESS: outputs held stable; counter decrements each cycle; when counter==0 -> RESP.
- RESP: bus_rsp_valid=1 for exactly one cycle, region_sel=0, region_write=0; -> IDLE.
- bus_req_ready=0 in ACCESS and RESP; bus_req_* ignored outside IDLE; address captured at acceptance only.
- Reset (any state): async to IDLE, all outputs 0 except bus_req_ready which is 0 during reset and 1 in IDLE after release; in-flight request dropped, no response.

## Timing
- Acceptance edge T, hit with wait W: region_sel high cycles T+1..T+1+W; bus_rsp_valid at T+2+W; bus_req_ready back at T+3+W.
- Miss: bus_rsp_valid with bus_rsp_error at T+1; bus_req_ready at T+2.
- All outputs registered; no combinational path from bus_req_* to any output except none (bus_req_ready from state only).
- Minimum throughput: one request per 3+W cycles.

## Configuration
- MEM_CTRL_MISALIGN_CHK_EN defined: a request with bus_req_addr[1:0] != 0 is rejected as a miss (RESP with bus_rsp_error=1 at T+1, region_sel never asserted).
- Undefined: low address bits ignored for checking; misaligned addresses decode and pass through to region_addr unchanged.

## Structure
- Shared package risc_v_mike_pkg: REGION_BASE, REGION_LAST (arrays of ADDR_W), REGION_WAIT (arrays of WAIT_W), FSM state enum mem_ctrl_state_t.
- Defaults: 0 text 0x00400000–0x00400FFF wait 0; 1 data 0x10010000–0x10010FFF wait 1; 2 stack 0x7FFFE000–0x7FFFEFFF wait 1; 3 MMIO 0xFFFF0000–0xFFFFFFFF wait 3.
- One combinational sub-module risc_v_mem_region_decode: address -> hit, index, offset.

## Test plan
- Read 0x00400004 -> region_sel=0001, region_addr=0x4 for 1 cycle, rsp_valid at T+2, error=0, region=0.
- Write 0xFFFF0010 -> region_sel=1000, region_write=1, region_addr=0x10 for 4 cycles, rsp at T+5, region=3.
- Read 0x10F10000 -> no region_sel, rsp_valid+error at T+1, ready at T+2.
- Back-to-back valid held high with 0x10010000 then 0x7FFFEFFC -> second accepted only when ready returns; offsets 0x0 and 0xFFC.
- rst low during ACCESS of MMIO request -> region_sel=0 immediately, no rsp_valid; next request serviced normally.
- With MEM_CTRL_MISALIGN_CHK_EN, read 0x10010002 -> error at T+1; without it, region_sel=0010, region_addr=0x2.
